// File: rtl/issue_dispatcher.sv
// Issue controller: classifies fetched instructions, tracks per-station credits.
// Optional BRANCH_SERIALIZE_EN blocks issue while a branch is unresolved.
module issue_dispatcher #(
    parameter int ALU_RS_DEPTH = 4,
    parameter int BU_RS_DEPTH  = 2,
    parameter int LSU_RS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        instruction_valid,
    output logic        instruction_ready,
    output logic        issue_valid,
    output logic [1:0]  issue_rs_id,
    output logic [31:0] issue_instruction,
    input  logic [2:0]  rs_free,
    input  logic        branch_resolved,
    input  logic        flush,
    output logic        credit_error
);

    localparam int AW = $clog2(ALU_RS_DEPTH + 1);
    localparam int BW = $clog2(BU_RS_DEPTH + 1);
    localparam int LW = $clog2(LSU_RS_DEPTH + 1);

    localparam logic [AW-1:0] ALU_MAX = AW'(ALU_RS_DEPTH);
    localparam logic [BW-1:0] BU_MAX  = BW'(BU_RS_DEPTH);
    localparam logic [LW-1:0] LSU_MAX = LW'(LSU_RS_DEPTH);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_BU  = 2'd1,
        UNIT_LSU = 2'd2
    } unit_e;

    logic [6:0]    opcode;
    unit_e         unit;
    logic          has_credit;
    logic          in_run;
    logic          accept;
    logic          acc_alu;
    logic          acc_bu;
    logic          acc_lsu;
    logic          ovf_alu;
    logic          ovf_bu;
    logic          ovf_lsu;
    logic [AW-1:0] alu_credit;
    logic [BW-1:0] bu_credit;
    logic [LW-1:0] lsu_credit;

    assign opcode = instruction[6:0];

    // Unrecognised opcodes fall through to the ALU
    always_comb begin
        unit = UNIT_ALU;
        unique case (1'b1)
            opcode == OP_BRANCH: unit = UNIT_BU;
            opcode == OP_LOAD,
            opcode == OP_STORE:  unit = UNIT_LSU;
            opcode == OP_REG,
            opcode == OP_IMM:    unit = UNIT_ALU;
            default:             unit = UNIT_ALU;
        endcase
    end

    always_comb begin
        has_credit = 1'b0;
        case (unit)
            UNIT_ALU: has_credit = (alu_credit != '0);
            UNIT_BU:  has_credit = (bu_credit != '0);
            UNIT_LSU: has_credit = (lsu_credit != '0);
            default:  has_credit = 1'b0;
        endcase
    end

    assign instruction_ready = has_credit && in_run && !flush;
    assign accept  = instruction_valid && instruction_ready;
    assign acc_alu = accept && (unit == UNIT_ALU);
    assign acc_bu  = accept && (unit == UNIT_BU);
    assign acc_lsu = accept && (unit == UNIT_LSU);

`ifdef BRANCH_SERIALIZE_EN
    typedef enum logic {
        RUN,
        BRANCH_WAIT
    } state_e;

    state_e state;
    state_e state_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            RUN: begin
                if (acc_bu) begin
                    state_next = BRANCH_WAIT;
                end
            end
            BRANCH_WAIT: begin
                if (branch_resolved || flush) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    assign in_run = (state == RUN);
`else
    logic unused_branch_resolved;

    assign unused_branch_resolved = branch_resolved;
    assign in_run = 1'b1;
`endif

    // Returns into an already-full counter are dropped and flagged
    assign ovf_alu = rs_free[0] && !acc_alu && (alu_credit == ALU_MAX);
    assign ovf_bu  = rs_free[1] && !acc_bu  && (bu_credit == BU_MAX);
    assign ovf_lsu = rs_free[2] && !acc_lsu && (lsu_credit == LSU_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_credit <= ALU_MAX;
        end else if (acc_alu && !rs_free[0]) begin
            alu_credit <= alu_credit - AW'(1);
        end else if (!acc_alu && rs_free[0] && !ovf_alu) begin
            alu_credit <= alu_credit + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bu_credit <= BU_MAX;
        end else if (acc_bu && !rs_free[1]) begin
            bu_credit <= bu_credit - BW'(1);
        end else if (!acc_bu && rs_free[1] && !ovf_bu) begin
            bu_credit <= bu_credit + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsu_credit <= LSU_MAX;
        end else if (acc_lsu && !rs_free[2]) begin
            lsu_credit <= lsu_credit - LW'(1);
        end else if (!acc_lsu && rs_free[2] && !ovf_lsu) begin
            lsu_credit <= lsu_credit + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_error <= 1'b0;
        end else if (ovf_alu || ovf_bu || ovf_lsu) begin
            credit_error <= 1'b1;
        end
    end

    // Flush blocks accept, so the pulse is suppressed for free
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issue_valid       <= 1'b0;
            issue_rs_id       <= 2'd0;
            issue_instruction <= 32'd0;
        end else begin
            issue_valid <= accept;
            if (accept) begin
                issue_rs_id       <= unit;
                issue_instruction <= instruction;
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatcher.sv
// Scoreboard bench for issue_dispatcher; adapts to BRANCH_SERIALIZE_EN.
module tb_issue_dispatcher;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] LWI  = 32'h0000A103;
    localparam logic [31:0] SWI  = 32'h00112023;
    localparam logic [31:0] BEQ  = 32'h00208463;
    localparam logic [31:0] UNK  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instruction = '0;
    logic        instruction_valid = 1'b0;
    logic        instruction_ready;
    logic        issue_valid;
    logic [1:0]  issue_rs_id;
    logic [31:0] issue_instruction;
    logic [2:0]  rs_free = '0;
    logic        branch_resolved = 1'b0;
    logic        flush = 1'b0;
    logic        credit_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];
    logic [33:0] mon_e;

    issue_dispatcher dut (
        .clk               (clk),
        .rst               (rst),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .instruction_ready (instruction_ready),
        .issue_valid       (issue_valid),
        .issue_rs_id       (issue_rs_id),
        .issue_instruction (issue_instruction),
        .rs_free           (rs_free),
        .branch_resolved   (branch_resolved),
        .flush             (flush),
        .credit_error      (credit_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && issue_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_issue", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_rs_id", issue_rs_id, mon_e[33:32]);
                check("issue_instr", issue_instruction, mon_e[31:0]);
            end
        end
    end

    task automatic issue_one(input logic [31:0] ins,
                             input logic [1:0] rs,
                             input logic [2:0] fr,
                             output int acc);
        acc = -1;
        instruction = ins;
        instruction_valid = 1'b1;
        rs_free = fr;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (instruction_ready) begin
                exp_q.push_back({rs, ins});
                @(posedge clk);
                @(negedge clk);
                acc = cyc;
                break;
            end
            @(negedge clk);
            rs_free = '0;
        end
        instruction_valid = 1'b0;
        rs_free = '0;
        if (acc < 0) check("accept_timeout", 0, 1);
    endtask

    task automatic ret(input logic [2:0] mask);
        rs_free = mask;
        @(negedge clk);
        rs_free = '0;
    endtask

    task automatic resolve();
        branch_resolved = 1'b1;
        @(negedge clk);
        branch_resolved = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a[4];
        int acc;
        int b;
        int c0;

        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_rs_id", issue_rs_id, 0);
        check("rst_instr", issue_instruction, 0);
        check("rst_credit_err", credit_error, 0);
        check("rst_ready", instruction_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) issue_one(ADD, 2'd0, 3'b000, a[i]);
        check("alu_back_to_back", a[3] - a[0], 3);

        instruction = ADD;
        instruction_valid = 1'b1;
        #1 check("alu_full_ready", instruction_ready, 0);
        @(negedge clk);
        #1 check("alu_full_hold", instruction_ready, 0);
        rs_free = 3'b001;
        c0 = cyc;
        #1 check("free_not_comb", instruction_ready, 0);
        @(negedge clk);
        rs_free = '0;
        issue_one(ADD, 2'd0, 3'b000, acc);
        check("credit_return_lat", acc - c0, 2);
        repeat (4) ret(3'b001);

        issue_one(LWI, 2'd2, 3'b100, acc);
        for (int i = 0; i < 4; i++) issue_one(LWI, 2'd2, 3'b000, acc);
        instruction = LWI;
        instruction_valid = 1'b1;
        #1 check("lsu_full_ready", instruction_ready, 0);
        instruction_valid = 1'b0;
        @(negedge clk);
        repeat (4) ret(3'b100);
        check("lsu_no_err", credit_error, 0);

        issue_one(SWI, 2'd2, 3'b000, acc);
        ret(3'b100);
        issue_one(ADDI, 2'd0, 3'b000, acc);
        ret(3'b001);
        issue_one(UNK, 2'd0, 3'b000, acc);
        ret(3'b001);

`ifdef BRANCH_SERIALIZE_EN
        issue_one(BEQ, 2'd1, 3'b000, b);
        instruction = ADD;
        instruction_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("branch_wait_ready", instruction_ready, 0);
            @(negedge clk);
        end
        branch_resolved = 1'b1;
        c0 = cyc;
        #1 check("resolve_not_comb", instruction_ready, 0);
        @(negedge clk);
        branch_resolved = 1'b0;
        issue_one(ADD, 2'd0, 3'b000, acc);
        check("branch_resolve_lat", acc - c0, 2);
`else
        issue_one(BEQ, 2'd1, 3'b000, b);
        issue_one(ADD, 2'd0, 3'b000, acc);
        check("branch_no_serial", acc - b, 1);
`endif
        ret(3'b010);
        ret(3'b001);

        issue_one(BEQ, 2'd1, 3'b000, b);
        instruction = ADD;
        instruction_valid = 1'b1;
        flush = 1'b1;
        #1 check("flush_ready", instruction_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        instruction_valid = 1'b0;
        check("flush_no_pulse", issue_valid, 0);
        #1 check("ready_after_flush", instruction_ready, 1);
        issue_one(ADD, 2'd0, 3'b000, acc);
        ret(3'b010);
        ret(3'b001);

        check("err_before_ovf", credit_error, 0);
        ret(3'b010);
        check("credit_error_set", credit_error, 1);
        issue_one(BEQ, 2'd1, 3'b000, acc);
        resolve();
        issue_one(BEQ, 2'd1, 3'b000, acc);
        resolve();
        instruction = BEQ;
        instruction_valid = 1'b1;
        #1 check("bu_credit_capped", instruction_ready, 0);
        instruction_valid = 1'b0;
        @(negedge clk);
        ret(3'b010);
        ret(3'b010);
        check("credit_err_sticky", credit_error, 1);

        issue_one(ADD, 2'd0, 3'b000, acc);
        #1 rst = 1'b0;
        #1;
        check("async_rst_valid", issue_valid, 0);
        check("async_rst_instr", issue_instruction, 0);
        check("async_rst_err", credit_error, 0);
        check("async_rst_ready", instruction_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue_one(LWI, 2'd2, 3'b000, acc);
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
